load_store_unit: RTL and testbench

//  Sits between the CPU execute stage and memctl. Accepts one RV32I load/store per handshake.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Handshake bundle between the execute stage, the load/store unit and memctl.
// The slave modport is the LSU's view; master is the pipeline/memctl side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] mem_addr;
  logic        mem_read_valid;
  logic        mem_write_valid;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_width;
  logic [31:0] mem_read_data;
  logic        mem_valid;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
           mem_read_data, mem_valid,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_read_valid, mem_write_valid, mem_write_data, mem_width
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
           mem_read_data, mem_valid,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_read_valid, mem_write_valid, mem_write_data, mem_width
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: legality/alignment check, memctl request, load extension.
// Optional macro LSU_TIMEOUT_EN adds a BUSY watchdog that answers with err=3.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst,
  load_store_unit_if.slave lsu
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_F3    = 2'd2;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [2:0]  funct3_q;
  logic [1:0]  width_q;
  logic [1:0]  err_q;
  logic        store_q;
  logic        rd_vld_q;
  logic        wr_vld_q;
  logic        resp_vld_q;

  logic        legal_d;
  logic        misaligned_d;
  logic [31:0] wdata_d;
  logic [31:0] ext_rdata_d;

  function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] mask_wdata(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] m;
    case (w)
      2'd0:    m = {24'd0, d[7:0]};
      2'd1:    m = {16'd0, d[15:0]};
      default: m = d;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b010:  r = d;
      3'b100:  r = {24'd0, d[7:0]};
      3'b101:  r = {16'd0, d[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    legal_d      = funct3_legal(lsu.req_store, lsu.req_funct3);
    misaligned_d = ((lsu.req_funct3[1:0] == 2'd1) && lsu.req_addr[0]) ||
                   ((lsu.req_funct3[1:0] == 2'd2) && (lsu.req_addr[1:0] != 2'd0));
    // Loads never put data on the write bus.
    wdata_d      = lsu.req_store ? mask_wdata(lsu.req_funct3[1:0], lsu.req_wdata) : 32'd0;
    ext_rdata_d  = extend_load(funct3_q, lsu.mem_read_data);
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_LOG = $clog2(TIMEOUT_CYCLES);
  localparam int TMO_W   = (TMO_LOG < 8) ? 8 : ((TMO_LOG > 32) ? 32 : TMO_LOG);

  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit_d;

  assign tmo_hit_d = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  logic [31:0] unused_tmo_cfg;
  assign unused_tmo_cfg = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      funct3_q   <= 3'd0;
      width_q    <= 2'd0;
      err_q      <= ERR_OK;
      store_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      wr_vld_q   <= 1'b0;
      resp_vld_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lsu.req_valid) begin
            addr_q   <= lsu.req_addr;
            funct3_q <= lsu.req_funct3;
            store_q  <= lsu.req_store;
            width_q  <= lsu.req_funct3[1:0];
            wdata_q  <= wdata_d;
            rdata_q  <= 32'd0;
            if (!legal_d) begin
              err_q      <= ERR_F3;
              resp_vld_q <= 1'b1;
              state_q    <= S_RESP;
            end else if (misaligned_d) begin
              err_q      <= ERR_ALIGN;
              resp_vld_q <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              err_q    <= ERR_OK;
              rd_vld_q <= ~lsu.req_store;
              wr_vld_q <= lsu.req_store;
              state_q  <= S_BUSY;
`ifdef LSU_TIMEOUT_EN
              tmo_q    <= '0;
`endif
            end
          end
        end

        S_BUSY: begin
          // mem_valid is checked first so a completion on the timeout cycle still succeeds.
          if (lsu.mem_valid) begin
            rd_vld_q   <= 1'b0;
            wr_vld_q   <= 1'b0;
            resp_vld_q <= 1'b1;
            err_q      <= ERR_OK;
            rdata_q    <= store_q ? 32'd0 : ext_rdata_d;
            state_q    <= S_RESP;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_hit_d) begin
            rd_vld_q   <= 1'b0;
            wr_vld_q   <= 1'b0;
            resp_vld_q <= 1'b1;
            err_q      <= 2'd3;
            rdata_q    <= 32'd0;
            state_q    <= S_RESP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end

        S_RESP: begin
          if (lsu.resp_ready) begin
            resp_vld_q <= 1'b0;
            err_q      <= ERR_OK;
            rdata_q    <= 32'd0;
            state_q    <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lsu.req_ready       = (state_q == S_IDLE);
  assign lsu.resp_valid      = resp_vld_q;
  assign lsu.resp_rdata      = rdata_q;
  assign lsu.resp_err        = err_q;
  assign lsu.mem_addr        = addr_q;
  assign lsu.mem_read_valid  = rd_vld_q;
  assign lsu.mem_write_valid = wr_vld_q;
  assign lsu.mem_write_data  = wdata_q;
  assign lsu.mem_width       = width_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-arithmetic reference model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;

  load_store_unit_if lif ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .lsu (lif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: sizes in bytes, modulo arithmetic for masking, signed wrap for extension.
  task automatic model(input bit st, input bit [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] md,
                       output logic [1:0] err, output logic [31:0] wexp,
                       output logic [31:0] rexp);
    bit     legal;
    int     nbytes;
    longint full;
    longint v;
    legal  = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = 1 << f3[1:0];
    wexp   = 32'd0;
    rexp   = 32'd0;
    if (!legal) err = 2'd2;
    else if ((a % nbytes) != 0) err = 2'd1;
    else err = 2'd0;
    if (legal) begin
      full = longint'(1) << (8 * nbytes);
      if (st) wexp = 32'(longint'(wd) % full);
      else if (err == 2'd0) begin
        v = longint'(md) % full;
        if (!f3[2] && nbytes < 4 && v >= full / 2) v = v - full;
        rexp = 32'(v);
      end
    end
  endtask

  task automatic wait_ready();
    int b;
    b = 0;
    while (!lif.req_ready && b < 50) begin
      @(posedge clk); #1;
      b++;
    end
    check("req_ready_wait", lif.req_ready, 1'b1);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_txn(input bit st, input bit [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] md,
                         input int dly, input int hold);
    logic [1:0]  e_err;
    logic [31:0] e_w;
    logic [31:0] e_r;
    model(st, f3, a, wd, md, e_err, e_w, e_r);
    wait_ready();
    lif.req_valid  = 1'b1;
    lif.req_store  = st;
    lif.req_funct3 = f3;
    lif.req_addr   = a;
    lif.req_wdata  = wd;
    @(posedge clk); #1;
    lif.req_valid = 1'b0;
    if (e_err != 2'd0) begin
      check("err_resp_valid", lif.resp_valid, 1'b1);
    end else begin
      check("mem_read_valid", lif.mem_read_valid, !st);
      check("mem_write_valid", lif.mem_write_valid, st);
      check("mem_width", lif.mem_width, f3[1:0]);
      check("mem_addr", lif.mem_addr, a);
      check("mem_write_data", lif.mem_write_data, e_w);
      check("busy_resp_valid", lif.resp_valid, 1'b0);
      for (int i = 0; i < dly; i++) begin
        @(posedge clk); #1;
        check("busy_wdata_stable", lif.mem_write_data, e_w);
        check("busy_valid_stable", {lif.mem_read_valid, lif.mem_write_valid}, {!st, st});
        check("busy_req_ready", lif.req_ready, 1'b0);
      end
      lif.mem_valid     = 1'b1;
      lif.mem_read_data = md;
      @(posedge clk); #1;
      lif.mem_valid     = 1'b0;
      lif.mem_read_data = $urandom;
      check("done_resp_valid", lif.resp_valid, 1'b1);
    end
    check("resp_err", lif.resp_err, e_err);
    check("resp_rdata", lif.resp_rdata, e_r);
    check("resp_mem_valids", {lif.mem_read_valid, lif.mem_write_valid}, 2'b00);
    for (int i = 0; i < hold; i++) begin
      lif.req_valid  = 1'b1;
      lif.req_funct3 = 3'b010;
      lif.req_addr   = $urandom & 32'hFFFF_FFFC;
      lif.mem_valid  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_resp_valid", lif.resp_valid, 1'b1);
      check("hold_rdata", lif.resp_rdata, e_r);
      check("hold_err", lif.resp_err, e_err);
      check("hold_req_ready", lif.req_ready, 1'b0);
      check("hold_mem_valids", {lif.mem_read_valid, lif.mem_write_valid}, 2'b00);
    end
    lif.req_valid  = 1'b0;
    lif.mem_valid  = 1'b0;
    lif.resp_ready = 1'b1;
    @(posedge clk); #1;
    lif.resp_ready = 1'b0;
    check("post_resp_valid", lif.resp_valid, 1'b0);
    check("post_req_ready", lif.req_ready, 1'b1);
  endtask

  initial begin
    lif.req_valid     = 1'b0;
    lif.req_store     = 1'b0;
    lif.req_funct3    = 3'd0;
    lif.req_addr      = 32'd0;
    lif.req_wdata     = 32'd0;
    lif.resp_ready    = 1'b0;
    lif.mem_read_data = 32'd0;
    lif.mem_valid     = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_req_ready", lif.req_ready, 1'b1);
    check("rst_resp_valid", lif.resp_valid, 1'b0);
    check("rst_mem_valids", {lif.mem_read_valid, lif.mem_write_valid}, 2'b00);
    check("rst_outputs", lif.resp_rdata | lif.mem_addr | lif.mem_write_data, 32'd0);
    check("rst_err_width", {lif.resp_err, lif.mem_width}, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Directed cases
    run_txn(1'b0, 3'b000, 32'h1003, 32'd0, 32'h0000_0080, 0, 0);
    run_txn(1'b0, 3'b001, 32'h1002, 32'd0, 32'h0000_8001, 0, 0);
    run_txn(1'b0, 3'b101, 32'h1002, 32'd0, 32'h0000_8001, 1, 0);
    run_txn(1'b1, 3'b010, 32'h1001, 32'h1234_5678, 32'd0, 0, 1);
    run_txn(1'b0, 3'b011, 32'h1000, 32'd0, 32'd0, 0, 0);
    run_txn(1'b1, 3'b000, 32'h1004, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3, 0);
    run_txn(1'b0, 3'b010, 32'h1000, 32'd0, 32'hCAFE_F00D, 2, 5);

    // mem_valid while idle changes nothing
    lif.mem_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lif.mem_valid = 1'b0;
    check("idle_memvalid_ready", lif.req_ready, 1'b1);
    check("idle_memvalid_resp", lif.resp_valid, 1'b0);

    // Load that memctl never answers
    wait_ready();
    lif.req_valid  = 1'b1;
    lif.req_store  = 1'b0;
    lif.req_funct3 = 3'b010;
    lif.req_addr   = 32'h1000;
    @(posedge clk); #1;
    lif.req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
    repeat (255) @(posedge clk);
    #1;
    check("tmo_not_yet", lif.resp_valid, 1'b0);
    check("tmo_still_reading", lif.mem_read_valid, 1'b1);
    @(posedge clk); #1;
    check("tmo_resp_valid", lif.resp_valid, 1'b1);
    check("tmo_err", lif.resp_err, 2'd3);
    check("tmo_rdata", lif.resp_rdata, 32'd0);
    check("tmo_read_valid", lif.mem_read_valid, 1'b0);
    lif.resp_ready = 1'b1;
    @(posedge clk); #1;
    lif.resp_ready = 1'b0;
    check("tmo_back_idle", lif.req_ready, 1'b1);
`else
    repeat (1000) @(posedge clk);
    #1;
    check("notmo_req_ready", lif.req_ready, 1'b0);
    check("notmo_read_valid", lif.mem_read_valid, 1'b1);
    check("notmo_resp_valid", lif.resp_valid, 1'b0);
    // Asynchronous reset in the middle of BUSY
    #2 rst = 1'b0;
    #1;
    check("arst_mem_valids", {lif.mem_read_valid, lif.mem_write_valid}, 2'b00);
    check("arst_resp_valid", lif.resp_valid, 1'b0);
    check("arst_req_ready", lif.req_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
`endif

    // Reset during a store BUSY
    wait_ready();
    lif.req_valid  = 1'b1;
    lif.req_store  = 1'b1;
    lif.req_funct3 = 3'b001;
    lif.req_addr   = 32'h2002;
    lif.req_wdata  = 32'h1357_9BDF;
    @(posedge clk); #1;
    lif.req_valid = 1'b0;
    check("pre_rst_write_valid", lif.mem_write_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_busy_mem_valids", {lif.mem_read_valid, lif.mem_write_valid}, 2'b00);
    check("rst_busy_resp_valid", lif.resp_valid, 1'b0);
    check("rst_busy_req_ready", lif.req_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_busy_after", lif.req_ready, 1'b1);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
